// File: rtl/mem_rsp_pkg.sv
// mem_rsp_pkg: shared widths and row/address types for the matrix-memory responder
package mem_rsp_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 256;
  localparam int LANE_W = 16;
  localparam int LANES  = 16;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] row_t;
endpackage

// File: rtl/mem_rsp_req_fifo.sv
// mem_rsp_req_fifo: request address FIFO exposing head, count and next-state count
module mem_rsp_req_fifo
  import mem_rsp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  addr_t         push_data_i,
  input  logic          pop_i,
  output addr_t         head_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o
);
  addr_t         mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  assign count_next_o = count_q + CW'(push_i) - CW'(pop_i);
  assign count_o      = count_q;
  assign head_o       = mem_q[rd_q];
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= push_i ? wr_q + PW'(1) : wr_q;
      rd_q    <= pop_i ? rd_q + PW'(1) : rd_q;
      count_q <= count_next_o;
    end
  end
  // storage needs no reset; count gates every read of it
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end
endmodule

// File: rtl/matrix_mem_responder.sv
// matrix_mem_responder: in-order SRAM read responder; MEM_RSP_LASTHIT_EN enables last-address hit reuse
module matrix_mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SRAM_LAT   = 1
) (
  input  logic  i_clk,
  input  logic  i_reset_n,
  input  logic  i_mem_rreq,
  input  addr_t i_mem_addr,
  output logic  o_mem_rrdy,
  output row_t  o_mem_dout,
  output logic  o_mem_dout_vld,
  output logic  o_sram_ren,
  output addr_t o_sram_addr,
  input  row_t  i_sram_rdata,
  input  logic  i_sram_busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic                push, pop, nonempty, hit, rrdy_q, dout_vld_q;
  addr_t               head, addr_q;
  row_t                dout_q, dout_d;
  logic [CW-1:0]       count, count_next;
  logic [SRAM_LAT-1:0] vld_q, vld_d, hit_q, hit_d;
  mem_rsp_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i        (i_clk),
    .rst_ni       (i_reset_n),
    .push_i       (push),
    .push_data_i  (i_mem_addr),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .count_next_o (count_next)
  );
  assign push     = i_mem_rreq && rrdy_q;
  assign nonempty = count != '0;
`ifdef MEM_RSP_LASTHIT_EN
  logic last_vld_q;
  assign hit = nonempty && last_vld_q && (head == addr_q);
  // addr_q is the last real read once any read has issued
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) last_vld_q <= 1'b0;
    else if (o_sram_ren) last_vld_q <= 1'b1;
  end
`else
  assign hit = 1'b0;
`endif
  assign o_sram_ren  = nonempty && !i_sram_busy && !hit;
  assign pop         = nonempty && (hit || !i_sram_busy);
  assign o_sram_addr = o_sram_ren ? head : addr_q;
  assign vld_d       = SRAM_LAT'({vld_q, pop});
  assign hit_d       = SRAM_LAT'({hit_q, hit});
  assign dout_d      = (vld_q[SRAM_LAT-1] && !hit_q[SRAM_LAT-1]) ? i_sram_rdata : dout_q;
  // ready, issued address, in-flight pipe and output register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rrdy_q     <= 1'b0;
      addr_q     <= '0;
      vld_q      <= '0;
      hit_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      rrdy_q     <= count_next < CW'(FIFO_DEPTH);
      addr_q     <= o_sram_addr;
      vld_q      <= vld_d;
      hit_q      <= hit_d;
      dout_q     <= dout_d;
      dout_vld_q <= vld_q[SRAM_LAT-1];
    end
  end
  assign o_mem_rrdy     = rrdy_q;
  assign o_mem_dout     = dout_q;
  assign o_mem_dout_vld = dout_vld_q;
endmodule

// File: tb/tb_matrix_mem_responder.sv
// tb_matrix_mem_responder: directed checks of the matrix-memory responder
module tb_matrix_mem_responder;
  import mem_rsp_pkg::*;
  logic  clk = 0, rst_n = 0, rreq = 0, busy = 0;
  addr_t addr = '0;
  logic  rrdy, vld, ren;
  row_t  dout, rdata = '0;
  addr_t saddr;
  int    cyc = 0, checks = 0, errors = 0;
  typedef struct {int c; addr_t a;} ren_t;
  typedef struct {int c; row_t d;} vld_t;
  ren_t  ren_log[$];
  vld_t  vld_log[$];

  always #5 clk = ~clk;

  matrix_mem_responder dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_mem_rreq     (rreq),
    .i_mem_addr     (addr),
    .o_mem_rrdy     (rrdy),
    .o_mem_dout     (dout),
    .o_mem_dout_vld (vld),
    .o_sram_ren     (ren),
    .o_sram_addr    (saddr),
    .i_sram_rdata   (rdata),
    .i_sram_busy    (busy)
  );

  function automatic row_t row(input int a);
    row_t r;
    for (int k = 0; k < LANES; k++) r[16*k +: 16] = 16'((a - 5) * 16 + k);
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ren) rdata <= row(int'(saddr));
  end

  always @(negedge clk) begin
    if (ren) ren_log.push_back('{cyc, saddr});
    if (vld) vld_log.push_back('{cyc, dout});
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs;
    ren_log.delete();
    vld_log.delete();
  endtask

  task automatic test_reset;
    rst_n = 0;
    step(2);
    @(negedge clk);
    checks++; if (rrdy !== 1'b0) begin errors++; $display("FAIL reset_rrdy: got %b expected 0", rrdy); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", vld); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
    checks++; if (ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b expected 0", ren); end
    checks++; if (saddr !== '0) begin errors++; $display("FAIL reset_saddr: got %h expected 0", saddr); end
    step;
    rst_n = 1;
    @(negedge clk);
    checks++; if (rrdy !== 1'b0) begin errors++; $display("FAIL reset_rrdy_release: got %b expected 0", rrdy); end
    step;
    checks++; if (rrdy !== 1'b1) begin errors++; $display("FAIL reset_rrdy_rise: got %b expected 1", rrdy); end
  endtask

  task automatic test_single;
    int t;
    clear_logs();
    t = cyc;
    rreq = 1;
    addr = 10'd5;
    step;
    rreq = 0;
    step(6);
    checks++; if (ren_log.size() != 1) begin errors++; $display("FAIL single_ren_cnt: got %0d expected 1", ren_log.size()); end
    if (ren_log.size() >= 1) begin
      checks++; if (ren_log[0].c != t + 1) begin errors++; $display("FAIL single_ren_cyc: got %0d expected %0d", ren_log[0].c, t + 1); end
      checks++; if (ren_log[0].a !== 10'd5) begin errors++; $display("FAIL single_ren_addr: got %0d expected 5", ren_log[0].a); end
    end
    checks++; if (vld_log.size() != 1) begin errors++; $display("FAIL single_vld_cnt: got %0d expected 1", vld_log.size()); end
    if (vld_log.size() >= 1) begin
      checks++; if (vld_log[0].c != t + 3) begin errors++; $display("FAIL single_vld_cyc: got %0d expected %0d", vld_log[0].c, t + 3); end
      checks++; if (vld_log[0].d[16*15 +: 16] !== 16'h000F) begin errors++; $display("FAIL single_lane15: got %h expected 000f", vld_log[0].d[16*15 +: 16]); end
      checks++; if (vld_log[0].d !== row(5)) begin errors++; $display("FAIL single_row: got %h expected %h", vld_log[0].d, row(5)); end
    end
  endtask

  task automatic test_stream;
    int t, lows;
    clear_logs();
    lows = 0;
    t = cyc;
    for (int i = 0; i < 18; i++) begin
      rreq = 1;
      addr = addr_t'(i);
      if (!rrdy) lows++;
      step;
    end
    rreq = 0;
    step(8);
    checks++; if (lows != 0) begin errors++; $display("FAIL stream_rrdy_low: got %0d low cycles expected 0", lows); end
    checks++; if (vld_log.size() != 18) begin errors++; $display("FAIL stream_cnt: got %0d expected 18", vld_log.size()); end
    if (vld_log.size() == 18) begin
      checks++; if (vld_log[0].c != t + 3) begin errors++; $display("FAIL stream_first_cyc: got %0d expected %0d", vld_log[0].c, t + 3); end
      for (int i = 0; i < 18; i++) begin
        checks++; if (vld_log[i].c != t + 3 + i) begin errors++; $display("FAIL stream_cyc[%0d]: got %0d expected %0d", i, vld_log[i].c, t + 3 + i); end
        checks++; if (vld_log[i].d !== row(i)) begin errors++; $display("FAIL stream_row[%0d]: got %h expected %h", i, vld_log[i].d, row(i)); end
      end
    end
  endtask

  task automatic test_backpressure;
    int a, acc, n;
    clear_logs();
    busy = 1;
    a = 20;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      rreq = 1;
      addr = addr_t'(a);
      if (i == 4) begin
        checks++; if (rrdy !== 1'b0) begin errors++; $display("FAIL bp_rrdy_after_full: got %b expected 0", rrdy); end
      end
      if (rrdy) begin a++; acc++; end
      step;
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepts: got %0d expected 4", acc); end
    checks++; if (ren_log.size() != 0) begin errors++; $display("FAIL bp_ren_while_busy: got %0d expected 0", ren_log.size()); end
    busy = 0;
    n = 0;
    while (a < 30 && n < 40) begin
      addr = addr_t'(a);
      if (rrdy) a++;
      n++;
      step;
    end
    rreq = 0;
    step(10);
    checks++; if (vld_log.size() != 10) begin errors++; $display("FAIL bp_cnt: got %0d expected 10", vld_log.size()); end
    for (int i = 0; i < vld_log.size() && i < 10; i++) begin
      checks++; if (vld_log[i].d !== row(20 + i)) begin errors++; $display("FAIL bp_row[%0d]: got %h expected %h", i, vld_log[i].d, row(20 + i)); end
    end
  endtask

  task automatic test_full;
    int a;
    clear_logs();
    busy = 1;
    a = 50;
    for (int i = 0; i < 4; i++) begin
      rreq = 1;
      addr = addr_t'(a);
      a++;
      step;
    end
    addr = addr_t'(a);
    for (int i = 0; i < 3; i++) begin
      checks++; if (rrdy !== 1'b0) begin errors++; $display("FAIL full_rrdy[%0d]: got %b expected 0", i, rrdy); end
      checks++; if (dut.u_fifo.count_o !== 3'd4) begin errors++; $display("FAIL full_count[%0d]: got %0d expected 4", i, dut.u_fifo.count_o); end
      step;
    end
    busy = 0;
    step;
    for (int i = 0; i < 3; i++) begin
      addr = addr_t'(a);
      checks++; if (rrdy !== 1'b1) begin errors++; $display("FAIL pushpop_rrdy[%0d]: got %b expected 1", i, rrdy); end
      checks++; if (dut.u_fifo.count_o !== 3'd3) begin errors++; $display("FAIL pushpop_count[%0d]: got %0d expected 3", i, dut.u_fifo.count_o); end
      a++;
      step;
    end
    rreq = 0;
    step(10);
    checks++; if (vld_log.size() != 7) begin errors++; $display("FAIL full_cnt: got %0d expected 7", vld_log.size()); end
    for (int i = 0; i < vld_log.size() && i < 7; i++) begin
      checks++; if (vld_log[i].d !== row(50 + i)) begin errors++; $display("FAIL full_row[%0d]: got %h expected %h", i, vld_log[i].d, row(50 + i)); end
    end
  endtask

  task automatic test_reset_mid;
    int t;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      rreq = 1;
      addr = addr_t'(40 + i);
      step;
    end
    rreq = 0;
    rst_n = 0;
    @(negedge clk);
    checks++; if (rrdy !== 1'b0) begin errors++; $display("FAIL midrst_rrdy: got %b expected 0", rrdy); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b expected 0", vld); end
    step;
    rst_n = 1;
    step(8);
    checks++; if (vld_log.size() != 0) begin errors++; $display("FAIL midrst_flush: got %0d pulses expected 0", vld_log.size()); end
    checks++; if (rrdy !== 1'b1) begin errors++; $display("FAIL midrst_rrdy_back: got %b expected 1", rrdy); end
    t = cyc;
    rreq = 1;
    addr = 10'd9;
    step;
    rreq = 0;
    step(6);
    checks++; if (vld_log.size() != 1) begin errors++; $display("FAIL midrst_post_cnt: got %0d expected 1", vld_log.size()); end
    if (vld_log.size() >= 1) begin
      checks++; if (vld_log[0].c != t + 3) begin errors++; $display("FAIL midrst_post_cyc: got %0d expected %0d", vld_log[0].c, t + 3); end
      checks++; if (vld_log[0].d !== row(9)) begin errors++; $display("FAIL midrst_post_row: got %h expected %h", vld_log[0].d, row(9)); end
    end
  endtask

  task automatic test_lasthit;
    int t, exp_reads;
    int seq [3] = '{7, 7, 8};
`ifdef MEM_RSP_LASTHIT_EN
    exp_reads = 2;
`else
    exp_reads = 3;
`endif
    clear_logs();
    t = cyc;
    for (int i = 0; i < 3; i++) begin
      rreq = 1;
      addr = addr_t'(seq[i]);
      step;
    end
    rreq = 0;
    step(8);
    checks++; if (ren_log.size() != exp_reads) begin errors++; $display("FAIL lasthit_reads: got %0d expected %0d", ren_log.size(), exp_reads); end
    if (ren_log.size() >= 1) begin
      checks++; if (ren_log[0].a !== 10'd7) begin errors++; $display("FAIL lasthit_first_addr: got %0d expected 7", ren_log[0].a); end
      checks++; if (ren_log[ren_log.size()-1].a !== 10'd8) begin errors++; $display("FAIL lasthit_last_addr: got %0d expected 8", ren_log[ren_log.size()-1].a); end
    end
    checks++; if (vld_log.size() != 3) begin errors++; $display("FAIL lasthit_cnt: got %0d expected 3", vld_log.size()); end
    for (int i = 0; i < vld_log.size() && i < 3; i++) begin
      checks++; if (vld_log[i].c != t + 3 + i) begin errors++; $display("FAIL lasthit_cyc[%0d]: got %0d expected %0d", i, vld_log[i].c, t + 3 + i); end
      checks++; if (vld_log[i].d !== row(seq[i])) begin errors++; $display("FAIL lasthit_row[%0d]: got %h expected %h", i, vld_log[i].d, row(seq[i])); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full();
    test_reset_mid();
    test_lasthit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
